// File: rtl/hazard_unit.sv
// hazard_unit: load-use hazard detector with saturating stall-cycle counter
package opcodes_pkg;
  typedef enum logic [5:0] {
    LUI, AUIPC, JAL, JALR,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    LB, LH, LW, LBU, LHU,
    SB, SH, SW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    OP_INVALID = 6'h3f
  } opcode_out_t;
endpackage

module hazard_unit
  import opcodes_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  opcode_out_t          opcode_in,
  input  logic [4:0]           id_reg1_idx,
  input  logic [4:0]           id_reg2_idx,
  input  logic [4:0]           ex_reg_wr_idx,
  input  logic                 ex_do_mem_read_en,
  output logic                 hazardFEEnable,
  output logic                 hazardIDEXClear,
  output logic [CNT_WIDTH-1:0] stall_count
);
  logic uses_rs1, uses_rs2, hazard;
  // decode which source registers the ID instruction actually reads
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode_in)
      ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU,
      BEQ, BNE, BLT, BGE, BLTU, BGEU, SB, SH, SW: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      JALR, LB, LH, LW, LBU, LHU,
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI: uses_rs1 = 1'b1;
      default: ;
    endcase
  end
  assign hazard = ex_do_mem_read_en && (ex_reg_wr_idx != 5'd0) &&
                  ((uses_rs1 && id_reg1_idx == ex_reg_wr_idx) ||
                   (uses_rs2 && id_reg2_idx == ex_reg_wr_idx));
  assign hazardIDEXClear = hazard;
  assign hazardFEEnable  = !hazard;
  // count stall cycles, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_count <= '0;
    else if (hazard && !(&stall_count)) stall_count <= stall_count + 1'b1;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: vector table, directed corner cases and randomized checks
module tb_hazard_unit;
  import opcodes_pkg::*;
  logic clk = 0, rst_n = 0, mr = 0;
  opcode_out_t op = ADD;
  logic [4:0] r1 = 0, r2 = 0, rd = 0;
  logic fe, clr, fe_s, clr_s;
  logic [31:0] cnt;
  logic [2:0] cnt_s;
  longint exp_cnt = 0;
  int exp_cnt_s = 0;
  int total = 0, bad = 0;
  opcode_out_t rs2_ops[$] = '{ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU,
                              BEQ, BNE, BLT, BGE, BLTU, BGEU, SB, SH, SW};
  opcode_out_t known_ops[$] = '{LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU,
                                LB, LH, LW, LBU, LHU, SB, SH, SW, ADDI, SLTI, SLTIU,
                                XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT,
                                SLTU, XOR, SRL, SRA, OR, AND};
  typedef struct {
    opcode_out_t op;
    logic [4:0] r1, r2, rd;
    logic mr, exp;
  } vec_t;
  vec_t vecs[$];

  hazard_unit dut (.clk(clk), .rst_n(rst_n), .opcode_in(op), .id_reg1_idx(r1),
    .id_reg2_idx(r2), .ex_reg_wr_idx(rd), .ex_do_mem_read_en(mr),
    .hazardFEEnable(fe), .hazardIDEXClear(clr), .stall_count(cnt));
  hazard_unit #(.CNT_WIDTH(3)) dut_s (.clk(clk), .rst_n(rst_n), .opcode_in(op),
    .id_reg1_idx(r1), .id_reg2_idx(r2), .ex_reg_wr_idx(rd), .ex_do_mem_read_en(mr),
    .hazardFEEnable(fe_s), .hazardIDEXClear(clr_s), .stall_count(cnt_s));

  always #5 clk = ~clk;

  function automatic bit in_list(opcode_out_t o, opcode_out_t l[$]);
    foreach (l[i]) if (l[i] == o) return 1;
    return 0;
  endfunction

  function automatic bit model(opcode_out_t o, logic [4:0] a, logic [4:0] b,
                               logic [4:0] d, logic m);
    bit u1 = in_list(o, known_ops) && !(o inside {LUI, AUIPC, JAL});
    bit u2 = in_list(o, rs2_ops);
    return m && d != 0 && ((u1 && a == d) || (u2 && b == d));
  endfunction

  task automatic chk(string name, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic step(string name, opcode_out_t o, logic [4:0] a, logic [4:0] b,
                      logic [4:0] d, logic m, bit e);
    op = o; r1 = a; r2 = b; rd = d; mr = m;
    #1;
    chk({name, ".clr"}, clr, e);
    chk({name, ".fe"}, fe, !e);
    @(posedge clk);
    #1;
    if (e) begin
      if (exp_cnt < 64'hffff_ffff) exp_cnt++;
      if (exp_cnt_s < 7) exp_cnt_s++;
    end
    chk({name, ".cnt"}, cnt, exp_cnt);
    chk({name, ".cnt_s"}, cnt_s, exp_cnt_s);
  endtask

  task automatic async_reset(string name);
    rst_n = 0;
    #1;
    exp_cnt = 0;
    exp_cnt_s = 0;
    chk({name, ".cnt"}, cnt, 0);
    chk({name, ".cnt_s"}, cnt_s, 0);
    #1 rst_n = 1;
  endtask

  initial begin
    #2;
    chk("rst.fe", fe, 1);
    chk("rst.clr", clr, 0);
    chk("rst.cnt", cnt, 0);
    op = ADD; r1 = 5; r2 = 2; rd = 5; mr = 1;
    #1;
    chk("rst.clr_follows", clr, 1);
    mr = 0;
    @(posedge clk);
    #1;
    chk("rst.cnt_held", cnt, 0);
    rst_n = 1;
    vecs.push_back('{ADD, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0});
    vecs.push_back('{ADD, 5'd5, 5'd2, 5'd5, 1'b1, 1'b1});
    vecs.push_back('{SW, 5'd1, 5'd7, 5'd7, 1'b1, 1'b1});
    vecs.push_back('{ADDI, 5'd1, 5'd7, 5'd7, 1'b1, 1'b0});
    vecs.push_back('{LUI, 5'd4, 5'd0, 5'd4, 1'b1, 1'b0});
    vecs.push_back('{AUIPC, 5'd4, 5'd4, 5'd4, 1'b1, 1'b0});
    vecs.push_back('{JAL, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0});
    vecs.push_back('{JALR, 5'd9, 5'd0, 5'd9, 1'b1, 1'b1});
    vecs.push_back('{ADD, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0});
    vecs.push_back('{ADD, 5'd6, 5'd6, 5'd6, 1'b0, 1'b0});
    vecs.push_back('{BGEU, 5'd3, 5'd31, 5'd31, 1'b1, 1'b1});
    vecs.push_back('{LW, 5'd31, 5'd2, 5'd31, 1'b1, 1'b1});
    vecs.push_back('{LW, 5'd2, 5'd31, 5'd31, 1'b1, 1'b0});
    vecs.push_back('{OP_INVALID, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0});
    vecs.push_back('{SRAI, 5'd1, 5'd1, 5'd2, 1'b1, 1'b0});
    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].op, vecs[i].r1, vecs[i].r2, vecs[i].rd,
           vecs[i].mr, vecs[i].exp);
    async_reset("areset1");
    for (int i = 0; i < 3; i++) step("hold3", ADD, 5'd5, 5'd2, 5'd5, 1'b1, 1'b1);
    chk("hold3.total", cnt, 3);
    op = ADD; r1 = 5; rd = 5; mr = 1;
    #2;
    async_reset("midstall");
    chk("midstall.clr", clr, 1);
    chk("midstall.fe", fe, 0);
    for (int i = 0; i < 10; i++) step("sat", SB, 5'd0, 5'd12, 5'd12, 1'b1, 1'b1);
    chk("sat.small", cnt_s, 7);
    chk("sat.big", cnt, 10);
    step("sat.idle", ADD, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    chk("sat.small_held", cnt_s, 7);
    for (int i = 0; i < 300; i++) begin
      int idx = $urandom_range(0, known_ops.size());
      opcode_out_t o = idx == known_ops.size() ? OP_INVALID : known_ops[idx];
      logic [4:0] a = 5'($urandom_range(0, 7));
      logic [4:0] b = 5'($urandom_range(0, 7));
      logic [4:0] d = 5'($urandom_range(0, 7));
      logic m = 1'($urandom_range(0, 1));
      step("rand", o, a, b, d, m, model(o, a, b, d, m));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
